ssd_scan_driver: RTL and testbench
==================================

# ssd_scan_driver

Parametrised seven-segment display driver for the board's eight-digit SSD bank. It replaces the fixed two-digit length display in the game top level. A binary value is loaded through a strobe and converted to BCD by a sequential double-dabble engine. The driver then time-multiplexes up to eight digits with leading-zero blanking, per-digit decimal points, an overflow indication and anti-ghosting blanking.

## Interface

Parameters:
- DIGITS, 8, number of driven digits, 1..8; an[7:DIGITS] are held high.
- BIN_W, 16, width of the binary input, 4..27.
- REFRESH_W, 18, per-digit dwell of 2^REFRESH_W board_clk cycles; must be at least 5.
- BLANK_LZ, 1, enables leading-zero blanking when set to 1.

Ports:
- board_clk, in, 1: system clock.
- reset, in, 1: asynchronous, active-high.
- value, in, BIN_W: binary number to display.
- load, in, 1: single-cycle strobe; samples value.
- dp_mask, in, DIGITS: bit i lights the decimal point of digit i, where digit 0 is rightmost.
- enable, in, 1: when low, all anodes are high (display dark); conversion is unaffected.
- busy, out, 1: high while a conversion is in progress.
- overflow, out, 1: committed value is at least 10^DIGITS.
- bcd, out, 4*DIGITS: committed BCD, with digit i at bits [4i+3:4i].
- an, out, 8: anodes, active-low.
- cathodes, out, 8: {Ca,Cb,Cc,Cd,Ce,Cf,Cg,Dp}, active-low.

## Operation

- **Reset:** every output takes a defined value.
  - busy=0, overflow=0, bcd=0.
  - an=8'hFF, cathodes=8'hFF.
  - Scan index=0, dwell counter=0, pending flag=0.
  - The committed value is 0.
- **Conversion:**
  - NDEC = ceil(BIN_W/3) internal BCD digits.
  - Each cycle performs one adjust-then-shift step (add 3 to any digit ≥5, then shift left one bit).
  - BIN_W steps complete a conversion.
- **Commit:**
  - bcd receives the low DIGITS digits.
  - overflow=1 if any internal digit at index ≥ DIGITS is nonzero.
  - bcd and overflow update on the same edge, so the display never tears.
- **Load while idle:** starts a conversion.
- **Load while busy:** value is captured into a one-deep pending register, and the latest capture wins. On the commit edge the pending value starts converting immediately, so busy stays high.
- **Load coincident with the commit edge:** treated as a load while busy.
- **Scan:**
  - The dwell counter is REFRESH_W bits wide.
  - The scan index advances on dwell wrap and runs 0..DIGITS-1, then wraps to 0.
  - an[idx] is low only when enable=1 and the dwell counter is ≥16 (ghost guard). Otherwise all anodes are high.
- **Cathodes during the guard:** held at 8'hFF.
- **Segment encoding:**

  | Symbol | Ca..Cg |
  |---|---|
  | 0 | 0000001 |
  | 1 | 1001111 |
  | 2 | 0010010 |
  | 3 | 0000110 |
  | 4 | 1001100 |
  | 5 | 0100100 |
  | 6 | 0100000 |
  | 7 | 0001111 |
  | 8 | 0000000 |
  | 9 | 0000100 |
  | dash | 1111110 |
  | blank | 1111111 |

  Dp = ~dp_mask[idx].
- **Blanking:** when BLANK_LZ=1, digits above the most-significant nonzero digit are blank. Digit 0 is never blanked.
- **Overflow display:** all digits show dash; blanking does not apply.

## Timing

- load sampled at edge E0:
  - busy=1 after E0.
  - Shift steps occur on E1..E_BIN_W.
  - Commit and busy=0 (no pending) occur on E_(BIN_W+1).
  - Latency is BIN_W+1 cycles.
- **Back-to-back conversions:** the pending start is on the commit edge, giving throughput of one result per BIN_W+1 cycles.
- **Scan outputs:** an and cathodes are registered, and change on the same edge as a dwell-counter transition.
- **Commit mid-dwell:** the new digit value appears on the next clock.
- **reset mid-conversion:** the conversion is aborted, the pending value is dropped, and no commit occurs.
- **load while reset is high:** ignored.

## Structure

- **Package ssd_pkg:**
  - Segment constants SEG_0..SEG_9, SEG_DASH, SEG_BLANK.
  - Function ndec(bin_w) returning ceil(bin_w/3).
  - Ghost-guard length constant GUARD_CYC=16.
- **Sub-module ssd_bin2bcd:**
  - Sequential double dabble with start/busy/done handshake.
  - Parameters BIN_W and NDEC.
- **Top block contains:**
  - Pending register.
  - Commit and overflow logic.
  - Scan counter.
  - Blanking logic.
  - Cathode encoder.

## Test plan

Defaults unless noted; REFRESH_W=5 in the bench.

1. After reset with no load, anodes scan 0..7. Digit 0 shows cathodes 8'b00000011; digits 1..7 show 8'hFF. For cycles 0..15 of each dwell, an=8'hFF.
2. Load value=1234:
   - busy is high for exactly 17 cycles.
   - bcd=32'h00001234.
   - Digits 3..0 show 1,2,3,4; digits 7..4 are blank.
3. DIGITS=4, load 65535: overflow=1 and all four digits show 8'b11111101. Load 9999: overflow=0 and bcd=16'h9999.
4. Load 7, then load 42 and load 99 during busy:
   - 7 commits first.
   - 99 converts next with no idle cycle; 42 is discarded.
   - Final bcd=...0099.
5. Assert reset 5 cycles after a load of 500: all outputs take reset values and bcd stays 0.
6. dp_mask=8'b00000100 with enable=0:
   - an stays 8'hFF throughout.
   - After enable=1, digit 2 shows Dp=0 and the other digits show Dp=1.

Source files
------------

// File: rtl/ssd_pkg.sv
// ssd_pkg: shared constants and helpers for the seven-segment scan driver.
//   - SEG_* : active-low segment patterns {Ca..Cg}
//   - GUARD_CYC : dark cycles at the start of each digit dwell (anti-ghosting)
//   - ndec() : number of BCD digits needed for a binary width
//   - seg_of() : decimal digit to segment pattern
package ssd_pkg;

  localparam int GUARD_CYC = 16;

  localparam logic [6:0] SEG_0     = 7'b0000001;
  localparam logic [6:0] SEG_1     = 7'b1001111;
  localparam logic [6:0] SEG_2     = 7'b0010010;
  localparam logic [6:0] SEG_3     = 7'b0000110;
  localparam logic [6:0] SEG_4     = 7'b1001100;
  localparam logic [6:0] SEG_5     = 7'b0100100;
  localparam logic [6:0] SEG_6     = 7'b0100000;
  localparam logic [6:0] SEG_7     = 7'b0001111;
  localparam logic [6:0] SEG_8     = 7'b0000000;
  localparam logic [6:0] SEG_9     = 7'b0000100;
  localparam logic [6:0] SEG_DASH  = 7'b1111110;
  localparam logic [6:0] SEG_BLANK = 7'b1111111;

  typedef enum logic {CONV_IDLE, CONV_RUN} conv_state_e;

  // 2^(3k) < 10^k, so every 3 input bits need at most one decimal digit.
  function automatic int ndec(input int bin_w);
    return (bin_w + 2) / 3;
  endfunction

  function automatic logic [6:0] seg_of(input logic [3:0] d);
    logic [6:0] s;
    case (d)
      4'd0:    s = SEG_0;
      4'd1:    s = SEG_1;
      4'd2:    s = SEG_2;
      4'd3:    s = SEG_3;
      4'd4:    s = SEG_4;
      4'd5:    s = SEG_5;
      4'd6:    s = SEG_6;
      4'd7:    s = SEG_7;
      4'd8:    s = SEG_8;
      4'd9:    s = SEG_9;
      default: s = SEG_BLANK;
    endcase
    return s;
  endfunction

endpackage

// File: rtl/ssd_bin2bcd.sv
// ssd_bin2bcd: sequential double-dabble converter, one adjust-then-shift
// step per cycle.
//   board_clk, reset : clock, async active-high reset
//   start, start_val : begin converting start_val (accepted when idle or
//                      in the done cycle, which allows back-to-back runs)
//   busy             : high from the start edge through the done cycle
//   done             : result on bcd is final; the next edge is the commit
//   bcd              : NDEC packed BCD digits
module ssd_bin2bcd
  import ssd_pkg::*;
#(
  parameter int BIN_W = 16,
  parameter int NDEC  = 6
) (
  input  logic              board_clk,
  input  logic              reset,
  input  logic              start,
  input  logic [BIN_W-1:0]  start_val,
  output logic              busy,
  output logic              done,
  output logic [4*NDEC-1:0] bcd
);

  localparam int CNT_W = $clog2(BIN_W + 1);

  conv_state_e       state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [BIN_W-1:0]  bin_q, bin_d;
  logic [4*NDEC-1:0] bcd_q, bcd_d;
  logic [4*NDEC-1:0] adj;

  always_comb begin
    adj = bcd_q;
    for (int i = 0; i < NDEC; i++) begin
      if (bcd_q[4*i +: 4] >= 4'd5) adj[4*i +: 4] = bcd_q[4*i +: 4] + 4'd3;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    bin_d   = bin_q;
    bcd_d   = bcd_q;
    case (state_q)
      CONV_IDLE: begin
        if (start) begin
          state_d = CONV_RUN;
          cnt_d   = CNT_W'(BIN_W);
          bin_d   = start_val;
          bcd_d   = '0;
        end
      end
      default: begin
        if (cnt_q != '0) begin
          {bcd_d, bin_d} = {adj[4*NDEC-2:0], bin_q, 1'b0};
          cnt_d          = cnt_q - CNT_W'(1);
        end else if (start) begin
          // restart on the commit edge so busy never drops
          cnt_d = CNT_W'(BIN_W);
          bin_d = start_val;
          bcd_d = '0;
        end else begin
          state_d = CONV_IDLE;
        end
      end
    endcase
  end

  always_ff @(posedge board_clk or posedge reset) begin
    if (reset) begin
      state_q <= CONV_IDLE;
      cnt_q   <= '0;
      bin_q   <= '0;
      bcd_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      bin_q   <= bin_d;
      bcd_q   <= bcd_d;
    end
  end

  assign busy = (state_q == CONV_RUN);
  assign done = (state_q == CONV_RUN) && (cnt_q == '0);
  assign bcd  = bcd_q;

endmodule

// File: rtl/ssd_scan_driver.sv
// ssd_scan_driver: loads a binary value, converts it to BCD and scans up to
// eight multiplexed seven-segment digits.
//   board_clk, reset : clock, async active-high reset
//   value, load      : binary value sampled on the load strobe
//   dp_mask          : per-digit decimal point, digit 0 rightmost
//   enable           : low keeps every anode high
//   busy             : conversion in progress
//   overflow         : committed value does not fit in DIGITS digits
//   bcd              : committed BCD, digit i at [4i+3:4i]
//   an, cathodes     : active-low anodes and {Ca..Cg,Dp}
module ssd_scan_driver
  import ssd_pkg::*;
#(
  parameter int DIGITS    = 8,
  parameter int BIN_W     = 16,
  parameter int REFRESH_W = 18,
  parameter int BLANK_LZ  = 1
) (
  input  logic                board_clk,
  input  logic                reset,
  input  logic [BIN_W-1:0]    value,
  input  logic                load,
  input  logic [DIGITS-1:0]   dp_mask,
  input  logic                enable,
  output logic                busy,
  output logic                overflow,
  output logic [4*DIGITS-1:0] bcd,
  output logic [7:0]          an,
  output logic [7:0]          cathodes
);

  localparam int NDEC  = ndec(BIN_W);
  localparam int PADN  = (NDEC > DIGITS) ? NDEC : DIGITS;
  localparam int IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;

  logic                     conv_start, conv_busy, conv_done;
  logic [BIN_W-1:0]         conv_val;
  logic [4*NDEC-1:0]        conv_bcd;
  logic [4*PADN-1:0]        bcd_pad;

  logic                     pend_vld_q, pend_vld_d;
  logic [BIN_W-1:0]         pend_val_q, pend_val_d;
  logic [DIGITS-1:0][3:0]   dig_q, dig_d;
  logic                     ovf_q, ovf_d;
  logic [REFRESH_W-1:0]     dwell_q, dwell_d;
  logic [IDX_W-1:0]         idx_q, idx_d;
  logic [7:0]               an_q, an_d;
  logic [7:0]               cath_q, cath_d;

  logic [DIGITS-1:0]        lz;
  logic                     all_zero;
  logic [3:0]               sel_dig;
  logic                     sel_blank, sel_dp;
  logic [6:0]               seg;

  ssd_bin2bcd #(.BIN_W(BIN_W), .NDEC(NDEC)) u_bin2bcd (
    .board_clk (board_clk),
    .reset     (reset),
    .start     (conv_start),
    .start_val (conv_val),
    .busy      (conv_busy),
    .done      (conv_done),
    .bcd       (conv_bcd)
  );

  // Start / pending control. A load on the commit edge is the newest
  // capture, so it beats any older pending value and starts right away.
  always_comb begin
    conv_start = 1'b0;
    conv_val   = value;
    pend_vld_d = pend_vld_q;
    pend_val_d = pend_val_q;
    if (conv_done) begin
      if (load) begin
        conv_start = 1'b1;
      end else if (pend_vld_q) begin
        conv_start = 1'b1;
        conv_val   = pend_val_q;
      end
      pend_vld_d = 1'b0;
    end else if (conv_busy) begin
      if (load) begin
        pend_vld_d = 1'b1;
        pend_val_d = value;
      end
    end else if (load) begin
      conv_start = 1'b1;
    end
  end

  // Commit: digits and overflow move together so the display never tears.
  assign bcd_pad = (4*PADN)'(conv_bcd);

  always_comb begin
    dig_d = dig_q;
    ovf_d = ovf_q;
    if (conv_done) begin
      for (int i = 0; i < DIGITS; i++) dig_d[i] = bcd_pad[4*i +: 4];
      ovf_d = |(bcd_pad >> (4*DIGITS));
    end
  end

  // Leading-zero blanking: a digit is blank when it and everything above it
  // is zero; digit 0 always shows.
  always_comb begin
    lz       = '0;
    all_zero = 1'b1;
    for (int i = DIGITS - 1; i >= 0; i--) begin
      all_zero = all_zero && (dig_q[i] == 4'd0);
      lz[i]    = (BLANK_LZ == 1) && all_zero && (i != 0);
    end
  end

  // Scan. an/cathodes are computed from the next dwell/index so the
  // registered outputs line up with the counter they belong to.
  always_comb begin
    dwell_d = dwell_q + REFRESH_W'(1);
    idx_d   = idx_q;
    if (&dwell_q) idx_d = (idx_q == IDX_W'(DIGITS - 1)) ? '0 : idx_q + IDX_W'(1);

    sel_dig   = 4'd0;
    sel_blank = 1'b0;
    sel_dp    = 1'b0;
    for (int i = 0; i < DIGITS; i++) begin
      if (idx_d == IDX_W'(i)) begin
        sel_dig   = dig_q[i];
        sel_blank = lz[i];
        sel_dp    = dp_mask[i];
      end
    end
    seg = ovf_q ? SEG_DASH : (sel_blank ? SEG_BLANK : seg_of(sel_dig));

    an_d   = 8'hFF;
    cath_d = 8'hFF;
    if (dwell_d >= REFRESH_W'(GUARD_CYC)) begin
      cath_d = {seg, ~sel_dp};
      if (enable) begin
        for (int i = 0; i < DIGITS; i++) begin
          if (idx_d == IDX_W'(i)) an_d[i] = 1'b0;
        end
      end
    end
  end

  always_ff @(posedge board_clk or posedge reset) begin
    if (reset) begin
      pend_vld_q <= 1'b0;
      pend_val_q <= '0;
      dig_q      <= '0;
      ovf_q      <= 1'b0;
      dwell_q    <= '0;
      idx_q      <= '0;
      an_q       <= 8'hFF;
      cath_q     <= 8'hFF;
    end else begin
      pend_vld_q <= pend_vld_d;
      pend_val_q <= pend_val_d;
      dig_q      <= dig_d;
      ovf_q      <= ovf_d;
      dwell_q    <= dwell_d;
      idx_q      <= idx_d;
      an_q       <= an_d;
      cath_q     <= cath_d;
    end
  end

  assign busy     = conv_busy;
  assign overflow = ovf_q;
  assign bcd      = dig_q;
  assign an       = an_q;
  assign cathodes = cath_q;

endmodule

// File: tb/tb_ssd_scan_driver.sv
// tb_ssd_scan_driver: drives an 8-digit and a 4-digit instance with shared
// stimulus and checks every cycle against a behavioural model built from
// decimal arithmetic and a cycle-count view of the scan.
module tb_ssd_scan_driver;

  localparam int BIN_W = 16;
  localparam int RW    = 5;
  localparam int DWELL = 1 << RW;

  logic             board_clk = 1'b0;
  logic             reset     = 1'b1;
  logic [BIN_W-1:0] value     = '0;
  logic             load      = 1'b0;
  logic [7:0]       dp_mask   = '0;
  logic             enable    = 1'b1;

  logic        busy8, ovf8, busy4, ovf4;
  logic [31:0] bcd8;
  logic [15:0] bcd4;
  logic [7:0]  an8, cath8, an4, cath4;

  int n_checks = 0;
  int n_fail   = 0;

  // model state
  int k = 0;            // edges since reset release
  bit act = 0;          // conversion in flight
  int left = 0;         // edges until commit
  int cur = 0;          // value being converted
  bit pv = 0;
  int pval = 0;
  int cm = 0;           // committed value
  logic [7:0] e_an8, e_cath8, e_an4, e_cath4;

  always #5 board_clk = ~board_clk;

  ssd_scan_driver #(.DIGITS(8), .BIN_W(BIN_W), .REFRESH_W(RW), .BLANK_LZ(1)) u_dut8 (
    .board_clk (board_clk), .reset (reset), .value (value), .load (load),
    .dp_mask (dp_mask), .enable (enable), .busy (busy8), .overflow (ovf8),
    .bcd (bcd8), .an (an8), .cathodes (cath8)
  );

  ssd_scan_driver #(.DIGITS(4), .BIN_W(BIN_W), .REFRESH_W(RW), .BLANK_LZ(1)) u_dut4 (
    .board_clk (board_clk), .reset (reset), .value (value), .load (load),
    .dp_mask (dp_mask[3:0]), .enable (enable), .busy (busy4), .overflow (ovf4),
    .bcd (bcd4), .an (an4), .cathodes (cath4)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s k=%0d got=%h want=%h", tag, k, obs, exp);
    end
  endtask

  function automatic int p10(input int n);
    int r = 1;
    for (int i = 0; i < n; i++) r *= 10;
    return r;
  endfunction

  function automatic logic [6:0] segtab(input int d);
    case (d)
      0: return 7'b0000001;
      1: return 7'b1001111;
      2: return 7'b0010010;
      3: return 7'b0000110;
      4: return 7'b1001100;
      5: return 7'b0100100;
      6: return 7'b0100000;
      7: return 7'b0001111;
      8: return 7'b0000000;
      9: return 7'b0000100;
      10: return 7'b1111110;
      default: return 7'b1111111;
    endcase
  endfunction

  function automatic logic [31:0] bcd_of(input int v, input int d);
    logic [31:0] r = '0;
    for (int i = 0; i < d; i++) r[4*i +: 4] = 4'((v / p10(i)) % 10);
    return r;
  endfunction

  function automatic logic [7:0] exp_cath(input int d, input int kk, input int v, input logic [7:0] dpm);
    int dw = kk % DWELL;
    int idx = (kk / DWELL) % d;
    int sym;
    if (dw < 16) return 8'hFF;
    if (v >= p10(d)) sym = 10;
    else if (idx > 0 && v < p10(idx)) sym = 11;
    else sym = (v / p10(idx)) % 10;
    return {segtab(sym), ~dpm[idx]};
  endfunction

  function automatic logic [7:0] exp_an(input int d, input int kk, input logic en);
    int dw = kk % DWELL;
    int idx = (kk / DWELL) % d;
    logic [7:0] r = 8'hFF;
    if (en && dw >= 16) r[idx] = 1'b0;
    return r;
  endfunction

  function automatic void model_reset();
    k = 0; act = 0; left = 0; pv = 0; cm = 0;
  endfunction

  // One clock edge: the display reflects the value committed before it.
  function automatic void model_edge();
    k++;
    e_an8   = exp_an(8, k, enable);
    e_an4   = exp_an(4, k, enable);
    e_cath8 = exp_cath(8, k, cm, dp_mask);
    e_cath4 = exp_cath(4, k, cm, dp_mask);
    if (act) begin
      left--;
      if (left == 0) begin
        cm = cur;
        if (load) begin cur = int'(value); left = BIN_W + 1; end
        else if (pv) begin cur = pval; left = BIN_W + 1; end
        else act = 0;
        pv = 0;
      end else if (load) begin
        pv = 1; pval = int'(value);
      end
    end else if (load) begin
      act = 1; cur = int'(value); left = BIN_W + 1;
    end
  endfunction

  task automatic check_all();
    chk("busy8", 32'(busy8), 32'(act));
    chk("busy4", 32'(busy4), 32'(act));
    chk("bcd8", bcd8, bcd_of(cm, 8));
    chk("bcd4", 32'(bcd4), bcd_of(cm, 4));
    chk("ovf8", 32'(ovf8), 32'(cm >= p10(8)));
    chk("ovf4", 32'(ovf4), 32'(cm >= p10(4)));
    chk("an8", 32'(an8), 32'(e_an8));
    chk("an4", 32'(an4), 32'(e_an4));
    chk("cath8", 32'(cath8), 32'(e_cath8));
    chk("cath4", 32'(cath4), 32'(e_cath4));
  endtask

  task automatic check_reset();
    chk("rst_busy", 32'({busy8, busy4}), 32'd0);
    chk("rst_ovf", 32'({ovf8, ovf4}), 32'd0);
    chk("rst_bcd8", bcd8, 32'd0);
    chk("rst_bcd4", 32'(bcd4), 32'd0);
    chk("rst_an", 32'({an8, an4}), 32'hFFFF);
    chk("rst_cath", 32'({cath8, cath4}), 32'hFFFF);
  endtask

  task automatic tick();
    @(posedge board_clk);
    model_edge();
    #1;
    check_all();
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic do_load(input int v);
    value = BIN_W'(v);
    load  = 1'b1;
    tick();
    load  = 1'b0;
  endtask

  initial begin
    int bcnt;
    // reset with load asserted: it must be ignored
    load = 1'b1; value = 16'd77;
    repeat (3) @(posedge board_clk);
    #1;
    model_reset();
    check_reset();
    load = 1'b0; reset = 1'b0;

    // idle scan over all digits
    run(8 * DWELL + 8);

    // 1234, with busy length measured explicitly
    value = 16'd1234; load = 1'b1;
    tick();
    load = 1'b0;
    bcnt = busy8 ? 1 : 0;
    for (int i = 0; i < 30; i++) begin tick(); if (busy8) bcnt++; end
    chk("busy_len", 32'(bcnt), 32'd17);
    chk("bcd_1234", bcd8, 32'h00001234);
    run(8 * DWELL);

    // overflow on the 4-digit instance, then the 4-digit maximum
    do_load(65535); run(20);
    chk("ovf4_65535", 32'(ovf4), 32'd1);
    run(4 * DWELL);
    do_load(9999); run(20);
    chk("bcd4_9999", 32'(bcd4), 32'h9999);
    chk("ovf4_9999", 32'(ovf4), 32'd0);

    // pending: 7 commits, 42 is replaced by 99
    do_load(7); run(3); do_load(42); run(4); do_load(99); run(45);
    chk("bcd_99", bcd8, 32'h00000099);

    // load exactly on the commit edge
    do_load(3); run(16); do_load(5); run(20);
    chk("bcd_5", bcd8, 32'h00000005);

    // reset mid-conversion
    do_load(500); run(5);
    reset = 1'b1; #1;
    model_reset();
    check_reset();
    load = 1'b1; value = 16'd321;
    repeat (2) @(posedge board_clk);
    #1;
    check_reset();
    load = 1'b0; reset = 1'b0;
    run(30);
    chk("bcd_after_rst", bcd8, 32'd0);

    // decimal point with display disabled, then enabled
    dp_mask = 8'b00000100; enable = 1'b0;
    run(8 * DWELL);
    enable = 1'b1;
    run(8 * DWELL);

    // randomized traffic
    for (int c = 0; c < 1500; c++) begin
      if ($urandom_range(0, 11) == 0) begin
        load  = 1'b1;
        value = ($urandom_range(0, 1) == 1) ? BIN_W'($urandom_range(0, 120)) : BIN_W'($urandom);
      end
      if ($urandom_range(0, 99) == 0) enable = ~enable;
      if ($urandom_range(0, 199) == 0) dp_mask = 8'($urandom);
      tick();
      load = 1'b0;
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
